// File: rtl/sram_port_arbiter_if.sv
// Requester-side and SRAM-side signal bundle for sram_port_arbiter.
// The slave modport belongs to the arbiter; master is the surrounding logic.
interface sram_port_arbiter_if #(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_we;
  logic [NREQ*ADDR_WIDTH-1:0] req_addr;
  logic [NREQ*DATA_WIDTH-1:0] req_wdata;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ-1:0]            rsp_valid;
  logic [NREQ*DATA_WIDTH-1:0] rsp_rdata;
  logic [ADDR_WIDTH-1:0]      sram_addr_a;
  logic [ADDR_WIDTH-1:0]      sram_addr_b;
  logic [DATA_WIDTH-1:0]      sram_data_a;
  logic [DATA_WIDTH-1:0]      sram_data_b;
  logic                       sram_we_a;
  logic                       sram_we_b;
  logic [DATA_WIDTH-1:0]      sram_q_a;
  logic [DATA_WIDTH-1:0]      sram_q_b;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, sram_q_a, sram_q_b,
    output req_ready, rsp_valid, rsp_rdata,
    output sram_addr_a, sram_addr_b, sram_data_a, sram_data_b, sram_we_a, sram_we_b
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, sram_q_a, sram_q_b,
    input  req_ready, rsp_valid, rsp_rdata,
    input  sram_addr_a, sram_addr_b, sram_data_a, sram_data_b, sram_we_a, sram_we_b
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing both ports of a dual-port SRAM among NREQ requesters,
// with same-address write conflict suppression and 1-cycle read response routing.
module sram_port_arbiter #(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input logic                clk,
  input logic                rst_n,
  sram_port_arbiter_if.slave bus
);
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0] r_ptr;
  logic             r_pend_a, r_pend_b;
  logic [PTR_W-1:0] r_id_a, r_id_b;

  logic             w_gnt_a, w_gnt_b;
  logic [PTR_W-1:0] w_id_a, w_id_b;
  logic [NREQ-1:0]  w_gnt_vec;

  function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] id);
    if (int'(id) == NREQ - 1) return '0;
    return id + 1'b1;
  endfunction

  // Scan from r_ptr: first valid takes A, next non-conflicting valid takes B.
  always_comb begin
    int idx;
    idx       = 0;
    w_gnt_a   = 1'b0;
    w_gnt_b   = 1'b0;
    w_id_a    = '0;
    w_id_b    = '0;
    w_gnt_vec = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (bus.req_valid[idx]) begin
        if (!w_gnt_a) begin
          w_gnt_a        = 1'b1;
          w_id_a         = PTR_W'(idx);
          w_gnt_vec[idx] = 1'b1;
        end else if (!w_gnt_b &&
                     !((bus.req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH] ==
                        bus.req_addr[int'(w_id_a)*ADDR_WIDTH +: ADDR_WIDTH]) &&
                       (bus.req_we[idx] || bus.req_we[w_id_a]))) begin
          w_gnt_b        = 1'b1;
          w_id_b         = PTR_W'(idx);
          w_gnt_vec[idx] = 1'b1;
        end
      end
    end
  end

  assign bus.req_ready = w_gnt_vec & {NREQ{rst_n}};

  always_comb begin
    bus.sram_addr_a = '0;
    bus.sram_data_a = '0;
    bus.sram_we_a   = 1'b0;
    bus.sram_addr_b = '0;
    bus.sram_data_b = '0;
    bus.sram_we_b   = 1'b0;
    if (w_gnt_a) begin
      bus.sram_addr_a = bus.req_addr[int'(w_id_a)*ADDR_WIDTH +: ADDR_WIDTH];
      bus.sram_data_a = bus.req_wdata[int'(w_id_a)*DATA_WIDTH +: DATA_WIDTH];
      bus.sram_we_a   = bus.req_we[w_id_a] & rst_n;
    end
    if (w_gnt_b) begin
      bus.sram_addr_b = bus.req_addr[int'(w_id_b)*ADDR_WIDTH +: ADDR_WIDTH];
      bus.sram_data_b = bus.req_wdata[int'(w_id_b)*DATA_WIDTH +: DATA_WIDTH];
      bus.sram_we_b   = bus.req_we[w_id_b] & rst_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      r_pend_a <= 1'b0;
      r_pend_b <= 1'b0;
      r_id_a   <= '0;
      r_id_b   <= '0;
    end else begin
      if (w_gnt_b)      r_ptr <= next_idx(w_id_b);
      else if (w_gnt_a) r_ptr <= next_idx(w_id_a);
      r_pend_a <= w_gnt_a && !bus.req_we[w_id_a];
      r_pend_b <= w_gnt_b && !bus.req_we[w_id_b];
      r_id_a   <= w_id_a;
      r_id_b   <= w_id_b;
    end
  end

  // Responses follow the pend/id registers, so reset clears them immediately.
  always_comb begin
    bus.rsp_valid = '0;
    bus.rsp_rdata = '0;
    if (r_pend_a) begin
      bus.rsp_valid[r_id_a]                               = 1'b1;
      bus.rsp_rdata[int'(r_id_a)*DATA_WIDTH +: DATA_WIDTH] = bus.sram_q_a;
    end
    if (r_pend_b) begin
      bus.rsp_valid[r_id_b]                               = 1'b1;
      bus.rsp_rdata[int'(r_id_b)*DATA_WIDTH +: DATA_WIDTH] = bus.sram_q_b;
    end
  end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: grant table plus multi-cycle sequences
// against a behavioural dual-port SRAM with registered read data.
module tb_sram_port_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int AW   = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sram_port_arbiter_if #(.NREQ(NREQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  sram_port_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Unwritten locations read back as A500_0000 | addr.
  logic [DW-1:0] mem [0:1023];
  bit            wr  [0:1023];

  function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
    return wr[a] ? mem[a] : (32'hA500_0000 | DW'(a));
  endfunction

  always @(posedge clk) begin
    bus.sram_q_a <= rd(bus.sram_addr_a);
    bus.sram_q_b <= rd(bus.sram_addr_b);
    if (bus.sram_we_a) begin
      mem[bus.sram_addr_a] <= bus.sram_data_a;
      wr[bus.sram_addr_a]  <= 1'b1;
    end
    if (bus.sram_we_b) begin
      mem[bus.sram_addr_b] <= bus.sram_data_b;
      wr[bus.sram_addr_b]  <= 1'b1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[i]            = v;
    bus.req_we[i]               = we;
    bus.req_addr[i*AW +: AW]    = a;
    bus.req_wdata[i*DW +: DW]   = d;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    clear_reqs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0]    v;
    logic [3:0]    we;
    logic [AW-1:0] a [4];
    logic [3:0]    rdy;
    logic          ga;
    int            ida;
    logic          gb;
    int            idb;
  } vec_t;

  vec_t tbl [10];

  task automatic setv(input int n, input logic [3:0] v, input logic [3:0] we,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [AW-1:0] a2, input logic [AW-1:0] a3,
                      input logic [3:0] rdy, input logic ga, input int ida,
                      input logic gb, input int idb);
    tbl[n].v = v; tbl[n].we = we;
    tbl[n].a[0] = a0; tbl[n].a[1] = a1; tbl[n].a[2] = a2; tbl[n].a[3] = a3;
    tbl[n].rdy = rdy; tbl[n].ga = ga; tbl[n].ida = ida; tbl[n].gb = gb; tbl[n].idb = idb;
  endtask

  logic [3:0]   exp_rsp;
  logic [3:0]   nxt_rsp;
  logic [3:0]   prev_rdy;
  logic [127:0] exp_data;
  int           cnt [4];

  initial begin
    // Pointer state is carried from row to row; rows start with ptr = 2.
    setv(0, 4'b1111, 4'b0000, 10'd1,  10'd2,  10'd3,  10'd4,  4'b1100, 1'b1, 2, 1'b1, 3);
    setv(1, 4'b1111, 4'b0000, 10'd1,  10'd2,  10'd3,  10'd4,  4'b0011, 1'b1, 0, 1'b1, 1);
    setv(2, 4'b0001, 4'b0000, 10'd7,  10'd0,  10'd0,  10'd0,  4'b0001, 1'b1, 0, 1'b0, 0);
    setv(3, 4'b0000, 4'b0000, 10'd0,  10'd0,  10'd0,  10'd0,  4'b0000, 1'b0, 0, 1'b0, 0);
    setv(4, 4'b1001, 4'b0001, 10'd5,  10'd0,  10'd0,  10'd5,  4'b1000, 1'b1, 3, 1'b0, 0);
    setv(5, 4'b0111, 4'b0001, 10'd5,  10'd5,  10'd9,  10'd0,  4'b0101, 1'b1, 0, 1'b1, 2);
    setv(6, 4'b1111, 4'b0000, 10'd16, 10'd16, 10'd16, 10'd16, 4'b1001, 1'b1, 3, 1'b1, 0);
    setv(7, 4'b0110, 4'b0110, 10'd0,  10'd32, 10'd32, 10'd0,  4'b0010, 1'b1, 1, 1'b0, 0);
    setv(8, 4'b0110, 4'b0100, 10'd0,  10'd33, 10'd33, 10'd0,  4'b0100, 1'b1, 2, 1'b0, 0);
    setv(9, 4'b0011, 4'b0000, 10'd1,  10'd2,  10'd0,  10'd0,  4'b0011, 1'b1, 0, 1'b1, 1);

    // Reset with every requester asking
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, AW'(i + 1), 32'h1000_0000 + i);
    tick();
    tick();
    chk("rst_ready", 128'(bus.req_ready), 128'd0);
    chk("rst_we_a", 128'(bus.sram_we_a), 128'd0);
    chk("rst_we_b", 128'(bus.sram_we_b), 128'd0);
    chk("rst_rsp_valid", 128'(bus.rsp_valid), 128'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 128'(bus.req_ready), 128'b0011);
    chk("post_rst_addr_a", 128'(bus.sram_addr_a), 128'd1);
    chk("post_rst_addr_b", 128'(bus.sram_addr_b), 128'd2);
    tick();

    // Grant table
    exp_rsp = 4'b0011;
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < NREQ; i++)
        set_req(i, tbl[n].v[i], tbl[n].we[i], tbl[n].a[i], 32'h1000_0000 + i);
      #1;
      chk($sformatf("tbl%0d_ready", n), 128'(bus.req_ready), 128'(tbl[n].rdy));
      chk($sformatf("tbl%0d_rsp_valid", n), 128'(bus.rsp_valid), 128'(exp_rsp));
      chk($sformatf("tbl%0d_addr_a", n), 128'(bus.sram_addr_a),
          tbl[n].ga ? 128'(tbl[n].a[tbl[n].ida]) : 128'd0);
      chk($sformatf("tbl%0d_we_a", n), 128'(bus.sram_we_a),
          tbl[n].ga ? 128'(tbl[n].we[tbl[n].ida]) : 128'd0);
      chk($sformatf("tbl%0d_data_a", n), 128'(bus.sram_data_a),
          tbl[n].ga ? 128'(32'h1000_0000 + tbl[n].ida) : 128'd0);
      chk($sformatf("tbl%0d_addr_b", n), 128'(bus.sram_addr_b),
          tbl[n].gb ? 128'(tbl[n].a[tbl[n].idb]) : 128'd0);
      chk($sformatf("tbl%0d_we_b", n), 128'(bus.sram_we_b),
          tbl[n].gb ? 128'(tbl[n].we[tbl[n].idb]) : 128'd0);
      nxt_rsp = '0;
      if (tbl[n].ga && !tbl[n].we[tbl[n].ida]) nxt_rsp[tbl[n].ida] = 1'b1;
      if (tbl[n].gb && !tbl[n].we[tbl[n].idb]) nxt_rsp[tbl[n].idb] = 1'b1;
      exp_rsp = nxt_rsp;
      tick();
    end

    // Write then read on requester 2
    do_reset();
    set_req(2, 1'b1, 1'b1, 10'h3A, 32'hDEADBEEF);
    #1;
    chk("wr_ready", 128'(bus.req_ready), 128'b0100);
    chk("wr_we_a", 128'(bus.sram_we_a), 128'd1);
    tick();
    set_req(2, 1'b1, 1'b0, 10'h3A, 32'h0);
    #1;
    chk("rd_ready", 128'(bus.req_ready), 128'b0100);
    chk("wr_no_rsp", 128'(bus.rsp_valid), 128'd0);
    tick();
    clear_reqs();
    #1;
    chk("rd_rsp_valid", 128'(bus.rsp_valid), 128'b0100);
    chk("rd_rsp_rdata", bus.rsp_rdata, 128'hDEADBEEF << 64);
    tick();

    // Fairness under continuous reads
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      set_req(i, 1'b1, 1'b0, AW'(10'h40 + i), 32'h0);
      cnt[i] = 0;
    end
    prev_rdy = '0;
    for (int c = 0; c < 7; c++) begin
      if (c == 6) clear_reqs();
      #1;
      if (c < 6)
        chk($sformatf("fair%0d_ready", c), 128'(bus.req_ready),
            (c % 2 == 0) ? 128'b0011 : 128'b1100);
      chk($sformatf("fair%0d_rsp_valid", c), 128'(bus.rsp_valid), 128'(prev_rdy));
      exp_data = '0;
      for (int i = 0; i < NREQ; i++) begin
        if (prev_rdy[i]) exp_data[i*DW +: DW] = 32'hA500_0040 + i;
        if (bus.rsp_valid[i]) cnt[i]++;
      end
      chk($sformatf("fair%0d_rdata", c), bus.rsp_rdata, exp_data);
      prev_rdy = (c < 6) ? ((c % 2 == 0) ? 4'b0011 : 4'b1100) : 4'b0000;
      tick();
    end
    for (int i = 0; i < NREQ; i++) chk($sformatf("fair_count%0d", i), 128'(cnt[i]), 128'd3);

    // Write/read conflict on address 5
    do_reset();
    set_req(0, 1'b1, 1'b1, 10'd5, 32'h55AA);
    set_req(1, 1'b1, 1'b0, 10'd5, 32'h0);
    set_req(2, 1'b1, 1'b0, 10'd9, 32'h0);
    #1;
    chk("cf_ready", 128'(bus.req_ready), 128'b0101);
    chk("cf_addr_a", 128'(bus.sram_addr_a), 128'd5);
    chk("cf_addr_b", 128'(bus.sram_addr_b), 128'd9);
    tick();
    set_req(0, 1'b0, 1'b0, 10'd0, 32'h0);
    set_req(2, 1'b0, 1'b0, 10'd0, 32'h0);
    #1;
    chk("cf2_ready", 128'(bus.req_ready), 128'b0010);
    chk("cf2_addr_a", 128'(bus.sram_addr_a), 128'd5);
    chk("cf2_rsp_valid", 128'(bus.rsp_valid), 128'b0100);
    chk("cf2_rdata", bus.rsp_rdata, 128'hA500_0009 << 64);
    tick();
    clear_reqs();
    #1;
    chk("cf3_rsp_valid", 128'(bus.rsp_valid), 128'b0010);
    chk("cf3_rdata", bus.rsp_rdata, 128'h55AA << 32);
    tick();

    // Same-address dual read
    set_req(0, 1'b1, 1'b1, 10'h10, 32'h1234);
    #1;
    chk("dr_wr_ready", 128'(bus.req_ready), 128'b0001);
    tick();
    set_req(0, 1'b1, 1'b0, 10'h10, 32'h0);
    set_req(1, 1'b1, 1'b0, 10'h10, 32'h0);
    #1;
    chk("dr_ready", 128'(bus.req_ready), 128'b0011);
    chk("dr_addr_a", 128'(bus.sram_addr_a), 128'h10);
    chk("dr_addr_b", 128'(bus.sram_addr_b), 128'h10);
    tick();
    clear_reqs();
    #1;
    chk("dr_rsp_valid", 128'(bus.rsp_valid), 128'b0011);
    chk("dr_rdata", bus.rsp_rdata, {64'h0, 32'h1234, 32'h1234});
    tick();

    // Reset arriving while a response is on the bus
    set_req(3, 1'b1, 1'b0, 10'h3A, 32'h0);
    #1;
    chk("mr_ready", 128'(bus.req_ready), 128'b1000);
    tick();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, AW'(i), 32'h0);
    #1;
    chk("mr_rsp_valid", 128'(bus.rsp_valid), 128'b1000);
    chk("mr_rdata", bus.rsp_rdata, 128'hDEADBEEF << 96);
    rst_n = 1'b0;
    #1;
    chk("mr_rst_rsp_valid", 128'(bus.rsp_valid), 128'd0);
    chk("mr_rst_rdata", bus.rsp_rdata, 128'd0);
    chk("mr_rst_ready", 128'(bus.req_ready), 128'd0);
    tick();
    clear_reqs();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("mr_post%0d_rsp_valid", c), 128'(bus.rsp_valid), 128'd0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
